// File: rtl/mipmap_optimized_ram_pkg.sv
// mipmap_optimized_ram_pkg: shared constants and helpers for the mipmap texel RAM.
package mipmap_optimized_ram_pkg;
    localparam string RAM_STYLE_BLOCK = "block";
    localparam string RAM_STYLE_DISTRIBUTED = "distributed";
    localparam string RAM_STYLE_AUTO = "auto";
    function automatic int laneCount(input int memWidth, input int strobeWidth);
        return memWidth / strobeWidth;
    endfunction
endpackage

// File: rtl/mipmap_optimized_ram_if.sv
// mipmap_optimized_ram_if: port A (read/write) and port B (read-only) texel RAM bus.
interface mipmap_optimized_ram_if
    import mipmap_optimized_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int MEM_WIDTH = 16,
    parameter int WRITE_STROBE_WIDTH = 16
) ();
    logic write;
    logic [ADDR_WIDTH-1:0] writeAddr;
    logic [MEM_WIDTH-1:0] writeData;
    logic [laneCount(MEM_WIDTH, WRITE_STROBE_WIDTH)-1:0] writeMask;
    logic [MEM_WIDTH-1:0] writeDataOut;
    logic [ADDR_WIDTH-1:0] readAddr;
    logic [MEM_WIDTH-1:0] readData;
    modport master (
        output write, writeAddr, writeData, writeMask, readAddr,
        input  writeDataOut, readData
    );
    modport slave (
        input  write, writeAddr, writeData, writeMask, readAddr,
        output writeDataOut, readData
    );
endinterface

// File: rtl/true_dual_port_ram_bank.sv
// true_dual_port_ram_bank: read-first lane-masked port A, read-only port B, 1-cycle registered outputs.
module true_dual_port_ram_bank
    import mipmap_optimized_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int MEM_WIDTH = 16,
    parameter int WRITE_STROBE_WIDTH = 16,
    parameter string MEMORY_PRIMITIVE = "block"
) (
    input  logic clk,
    input  logic reset,
    input  logic write,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [MEM_WIDTH-1:0] writeData,
    input  logic [laneCount(MEM_WIDTH, WRITE_STROBE_WIDTH)-1:0] writeMask,
    output logic [MEM_WIDTH-1:0] writeDataOut,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    output logic [MEM_WIDTH-1:0] readData
);
    (* ram_style = MEMORY_PRIMITIVE *) logic [MEM_WIDTH-1:0] mem [2**ADDR_WIDTH];
    // Non-blocking array update gives read-first on both ports; reset only clears output registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < laneCount(MEM_WIDTH, WRITE_STROBE_WIDTH); i++)
            if (write && writeMask[i])
                mem[writeAddr][i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH] <= writeData[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
        writeDataOut <= reset ? '0 : mem[writeAddr];
        readData <= reset ? '0 : mem[readAddr];
    end
endmodule

// File: rtl/mipmap_optimized_ram.sv
// mipmap_optimized_ram: texel bank RAM; with LOD optimization a half-size base bank plus a
// quarter-size mip bank cover a texture and its mip chain, the top quarter of the space aliasing.
module mipmap_optimized_ram
    import mipmap_optimized_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int MEM_WIDTH = 16,
    parameter int WRITE_STROBE_WIDTH = 16,
    parameter string MEMORY_PRIMITIVE = RAM_STYLE_BLOCK,
    parameter bit ENABLE_LOD_OPTIMIZATION = 1'b1
) (
    input logic clk,
    input logic reset,
    mipmap_optimized_ram_if.slave bus
);
    localparam int M = ADDR_WIDTH - 1;
    if (ENABLE_LOD_OPTIMIZATION) begin : gLod
        logic writeSel, readSel;
        logic [MEM_WIDTH-1:0] baseA, baseB, mipA, mipB;
        true_dual_port_ram_bank #(
            .ADDR_WIDTH(ADDR_WIDTH - 1), .MEM_WIDTH(MEM_WIDTH),
            .WRITE_STROBE_WIDTH(WRITE_STROBE_WIDTH), .MEMORY_PRIMITIVE(MEMORY_PRIMITIVE)
        ) baseBank (
            .clk(clk), .reset(reset),
            .write(bus.write && !bus.writeAddr[M]),
            .writeAddr(bus.writeAddr[M-1:0]), .writeData(bus.writeData), .writeMask(bus.writeMask),
            .writeDataOut(baseA), .readAddr(bus.readAddr[M-1:0]), .readData(baseB)
        );
        // Mip bank drops a[M-1], so the upper quarter of the address space aliases onto it.
        true_dual_port_ram_bank #(
            .ADDR_WIDTH(ADDR_WIDTH - 2), .MEM_WIDTH(MEM_WIDTH),
            .WRITE_STROBE_WIDTH(WRITE_STROBE_WIDTH), .MEMORY_PRIMITIVE(MEMORY_PRIMITIVE)
        ) mipBank (
            .clk(clk), .reset(reset),
            .write(bus.write && bus.writeAddr[M]),
            .writeAddr(bus.writeAddr[M-2:0]), .writeData(bus.writeData), .writeMask(bus.writeMask),
            .writeDataOut(mipA), .readAddr(bus.readAddr[M-2:0]), .readData(mipB)
        );
        always_ff @(posedge clk) begin
            writeSel <= reset ? 1'b0 : bus.writeAddr[M];
            readSel <= reset ? 1'b0 : bus.readAddr[M];
        end
        assign bus.writeDataOut = writeSel ? mipA : baseA;
        assign bus.readData = readSel ? mipB : baseB;
    end else begin : gFlat
        true_dual_port_ram_bank #(
            .ADDR_WIDTH(ADDR_WIDTH), .MEM_WIDTH(MEM_WIDTH),
            .WRITE_STROBE_WIDTH(WRITE_STROBE_WIDTH), .MEMORY_PRIMITIVE(MEMORY_PRIMITIVE)
        ) flatBank (
            .clk(clk), .reset(reset),
            .write(bus.write), .writeAddr(bus.writeAddr), .writeData(bus.writeData),
            .writeMask(bus.writeMask), .writeDataOut(bus.writeDataOut),
            .readAddr(bus.readAddr), .readData(bus.readData)
        );
    end
endmodule

// File: tb/tb_mipmap_optimized_ram.sv
// tb_mipmap_optimized_ram: directed checks of flat, wide-masked and LOD-aliased RAM instances.
module tb_mipmap_optimized_ram;
    logic clk, reset;
    int passCount = 0;
    int totalCount = 0;
    mipmap_optimized_ram_if #(.ADDR_WIDTH(4), .MEM_WIDTH(16), .WRITE_STROBE_WIDTH(16)) ifF ();
    mipmap_optimized_ram_if #(.ADDR_WIDTH(4), .MEM_WIDTH(32), .WRITE_STROBE_WIDTH(16)) ifW ();
    mipmap_optimized_ram_if #(.ADDR_WIDTH(4), .MEM_WIDTH(16), .WRITE_STROBE_WIDTH(16)) ifL ();
    mipmap_optimized_ram #(.ADDR_WIDTH(4), .MEM_WIDTH(16), .WRITE_STROBE_WIDTH(16),
        .MEMORY_PRIMITIVE("block"), .ENABLE_LOD_OPTIMIZATION(1'b0))
        dutF (.clk(clk), .reset(reset), .bus(ifF));
    mipmap_optimized_ram #(.ADDR_WIDTH(4), .MEM_WIDTH(32), .WRITE_STROBE_WIDTH(16),
        .MEMORY_PRIMITIVE("distributed"), .ENABLE_LOD_OPTIMIZATION(1'b0))
        dutW (.clk(clk), .reset(reset), .bus(ifW));
    mipmap_optimized_ram #(.ADDR_WIDTH(4), .MEM_WIDTH(16), .WRITE_STROBE_WIDTH(16),
        .MEMORY_PRIMITIVE("block"), .ENABLE_LOD_OPTIMIZATION(1'b1))
        dutL (.clk(clk), .reset(reset), .bus(ifL));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        {ifF.write, ifF.writeAddr, ifF.writeData, ifF.writeMask, ifF.readAddr} = '0;
        {ifW.write, ifW.writeAddr, ifW.writeData, ifW.writeMask, ifW.readAddr} = '0;
        {ifL.write, ifL.writeAddr, ifL.writeData, ifL.writeMask, ifL.readAddr} = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        totalCount++; if (ifF.readData !== 16'h0) $display("FAIL reset_F_rd got %h exp 0000", ifF.readData); else passCount++;
        totalCount++; if (ifF.writeDataOut !== 16'h0) $display("FAIL reset_F_wdo got %h exp 0000", ifF.writeDataOut); else passCount++;
        totalCount++; if (ifW.readData !== 32'h0) $display("FAIL reset_W_rd got %h exp 00000000", ifW.readData); else passCount++;
        totalCount++; if (ifL.readData !== 16'h0) $display("FAIL reset_L_rd got %h exp 0000", ifL.readData); else passCount++;
        totalCount++; if (ifL.writeDataOut !== 16'h0) $display("FAIL reset_L_wdo got %h exp 0000", ifL.writeDataOut); else passCount++;
    endtask

    task automatic test_basic_write_read();
        ifF.write = 1'b1; ifF.writeAddr = 4'd3; ifF.writeData = 16'h1234; ifF.writeMask = 1'b1;
        tick();
        ifF.writeData = 16'hBEEF; ifF.readAddr = 4'd3;
        tick();
        totalCount++; if (ifF.writeDataOut !== 16'h1234) $display("FAIL basic_wdo_readfirst got %h exp 1234", ifF.writeDataOut); else passCount++;
        totalCount++; if (ifF.readData !== 16'h1234) $display("FAIL basic_rd_collision got %h exp 1234", ifF.readData); else passCount++;
        ifF.write = 1'b0;
        tick();
        totalCount++; if (ifF.writeDataOut !== 16'hBEEF) $display("FAIL basic_wdo_new got %h exp beef", ifF.writeDataOut); else passCount++;
        totalCount++; if (ifF.readData !== 16'hBEEF) $display("FAIL basic_rd_new got %h exp beef", ifF.readData); else passCount++;
    endtask

    task automatic test_write_mask();
        ifW.write = 1'b1; ifW.writeAddr = 4'd5; ifW.writeData = 32'hAAAABBBB; ifW.writeMask = 2'b11;
        tick();
        ifW.writeData = 32'h11112222; ifW.writeMask = 2'b01;
        tick();
        ifW.write = 1'b0; ifW.readAddr = 4'd5;
        tick();
        totalCount++; if (ifW.readData !== 32'hAAAA2222) $display("FAIL mask_lo_rd got %h exp aaaa2222", ifW.readData); else passCount++;
        totalCount++; if (ifW.writeDataOut !== 32'hAAAA2222) $display("FAIL mask_lo_wdo got %h exp aaaa2222", ifW.writeDataOut); else passCount++;
        ifW.write = 1'b1; ifW.writeData = 32'h33334444; ifW.writeMask = 2'b10;
        tick();
        ifW.write = 1'b0;
        tick();
        totalCount++; if (ifW.readData !== 32'h33332222) $display("FAIL mask_hi_rd got %h exp 33332222", ifW.readData); else passCount++;
    endtask

    task automatic test_read_first();
        ifF.write = 1'b1; ifF.writeAddr = 4'd7; ifF.writeData = 16'h5555; ifF.writeMask = 1'b1;
        tick();
        ifF.writeData = 16'h6666; ifF.readAddr = 4'd7;
        tick();
        totalCount++; if (ifF.writeDataOut !== 16'h5555) $display("FAIL rf_wdo got %h exp 5555", ifF.writeDataOut); else passCount++;
        totalCount++; if (ifF.readData !== 16'h5555) $display("FAIL rf_rd got %h exp 5555", ifF.readData); else passCount++;
        ifF.write = 1'b0;
        tick();
        totalCount++; if (ifF.readData !== 16'h6666) $display("FAIL rf_rd_after got %h exp 6666", ifF.readData); else passCount++;
    endtask

    task automatic test_lod_alias();
        logic [3:0] wa [4] = '{4'h2, 4'h8, 4'hC, 4'hE};
        logic [15:0] wd [4] = '{16'h00A0, 16'h00B0, 16'h00C0, 16'h00D0};
        logic [3:0] ra [5] = '{4'h2, 4'h8, 4'hC, 4'hA, 4'h6};
        logic [3:0] pa [5] = '{4'hC, 4'h2, 4'h0, 4'hE, 4'h2};
        logic [15:0] rexp [5] = '{16'h00A0, 16'h00C0, 16'h00C0, 16'h00D0, 16'h0000};
        logic [15:0] pexp [5] = '{16'h00C0, 16'h00A0, 16'h0000, 16'h00D0, 16'h00A0};
        ifL.write = 1'b1; ifL.writeMask = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifL.writeAddr = wa[i]; ifL.writeData = wd[i];
            tick();
        end
        ifL.write = 1'b1; ifL.writeAddr = 4'h0; ifL.writeData = 16'h0000;
        tick();
        ifL.write = 1'b1; ifL.writeAddr = 4'h6;
        tick();
        ifL.write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifL.readAddr = ra[i]; ifL.writeAddr = pa[i];
            tick();
            totalCount++; if (ifL.readData !== rexp[i]) $display("FAIL lod_rd_%h got %h exp %h", ra[i], ifL.readData, rexp[i]); else passCount++;
            totalCount++; if (ifL.writeDataOut !== pexp[i]) $display("FAIL lod_wdo_%h got %h exp %h", pa[i], ifL.writeDataOut, pexp[i]); else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] cur;
        ifL.write = 1'b0; ifL.readAddr = 4'h2; ifL.writeAddr = 4'h8;
        tick();
        for (int i = 0; i < 6; i++) begin
            cur = ifL.readAddr;
            ifL.readAddr = cur == 4'h2 ? 4'h8 : 4'h2;
            ifL.writeAddr = cur;
            #1;
            totalCount++; if (ifL.readData !== (cur == 4'h2 ? 16'h00A0 : 16'h00C0)) $display("FAIL b2b_rd_%0d got %h exp %h", i, ifL.readData, cur == 4'h2 ? 16'h00A0 : 16'h00C0); else passCount++;
            totalCount++; if (ifL.writeDataOut !== (cur == 4'h2 ? 16'h00C0 : 16'h00A0)) $display("FAIL b2b_wdo_%0d got %h exp %h", i, ifL.writeDataOut, cur == 4'h2 ? 16'h00C0 : 16'h00A0); else passCount++;
            tick();
        end
    endtask

    task automatic test_mid_reset();
        ifL.readAddr = 4'h8; ifL.writeAddr = 4'h2;
        tick();
        totalCount++; if (ifL.readData !== 16'h00C0) $display("FAIL mr_pre_rd got %h exp 00c0", ifL.readData); else passCount++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        totalCount++; if (ifL.readData !== 16'h0) $display("FAIL mr_L_rd got %h exp 0000", ifL.readData); else passCount++;
        totalCount++; if (ifL.writeDataOut !== 16'h0) $display("FAIL mr_L_wdo got %h exp 0000", ifL.writeDataOut); else passCount++;
        totalCount++; if (ifW.readData !== 32'h0) $display("FAIL mr_W_rd got %h exp 00000000", ifW.readData); else passCount++;
        totalCount++; if (ifF.readData !== 16'h0) $display("FAIL mr_F_rd got %h exp 0000", ifF.readData); else passCount++;
        tick();
        totalCount++; if (ifL.readData !== 16'h00C0) $display("FAIL mr_post_L_rd got %h exp 00c0", ifL.readData); else passCount++;
        totalCount++; if (ifL.writeDataOut !== 16'h00A0) $display("FAIL mr_post_L_wdo got %h exp 00a0", ifL.writeDataOut); else passCount++;
        totalCount++; if (ifW.readData !== 32'h33332222) $display("FAIL mr_post_W_rd got %h exp 33332222", ifW.readData); else passCount++;
        totalCount++; if (ifF.readData !== 16'h6666) $display("FAIL mr_post_F_rd got %h exp 6666", ifF.readData); else passCount++;
    endtask

    initial begin
        test_reset();
        test_basic_write_read();
        test_write_mask();
        test_read_first();
        test_lod_alias();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
